// File: rtl/trap_if.sv
// Port bundle between the trap sequencer and its EX / CSR neighbours.
// The slave modport belongs to trap_ctrl; the master side drives requests and CSR read data.
interface trap_if #(
  parameter int XLEN = 32
);
  logic            inst_valid;
  logic [XLEN-1:0] inst_addr;
  logic            ecall;
  logic            ebreak;
  logic            mret;
  logic            busy;
  logic            ext_int;
  logic [XLEN-1:0] r_mstatus;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mie;
  logic [XLEN-1:0] r_mcause;
  logic            w_enable;
  logic            w_ctrl_enable;
  logic [XLEN-1:0] w_mstatus;
  logic [XLEN-1:0] w_mepc;
  logic [XLEN-1:0] w_mcause;
  logic            hold;
  logic            flush;
  logic            jump;
  logic [XLEN-1:0] jump_addr;
  logic            int_ack;

  modport slave (
    input  inst_valid, inst_addr, ecall, ebreak, mret, busy, ext_int,
           r_mstatus, r_mepc, r_mtvec, r_mie, r_mcause,
    output w_enable, w_ctrl_enable, w_mstatus, w_mepc, w_mcause,
           hold, flush, jump, jump_addr, int_ack
  );

  modport master (
    output inst_valid, inst_addr, ecall, ebreak, mret, busy, ext_int,
           r_mstatus, r_mepc, r_mtvec, r_mie, r_mcause,
    input  w_enable, w_ctrl_enable, w_mstatus, w_mepc, w_mcause,
           hold, flush, jump, jump_addr, int_ack
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap/interrupt sequencer: accepts ecall/ebreak/mret/external irq from EX, performs one
// atomic mstatus/mepc/mcause write, then redirects fetch to mtvec or mepc.
//
// state | meaning
// IDLE  | evaluate requests; accept cycle drives flush/hold (and int_ack for irq)
// WRITE | present latched CSR values on the ctrl write path, pipeline held
// JUMP  | redirect fetch to latched target, flush pipeline
module trap_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] CAUSE_ECALL  = 32'd11,
  parameter logic [XLEN-1:0] CAUSE_EBREAK = 32'd3,
  parameter logic [XLEN-1:0] CAUSE_EXTINT = 32'h8000000B
) (
  input  logic   clk,
  input  logic   rst_n,
  trap_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WRITE, JUMP} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] target_q, target_d;

  logic            irq_ok;
  logic            req;
  logic [XLEN-1:0] trap_mstatus;
  logic [XLEN-1:0] mret_mstatus;

  assign irq_ok = bus.ext_int & bus.r_mstatus[3] & bus.r_mie[11];
  assign req    = bus.inst_valid & ~bus.busy & (bus.mret | bus.ecall | bus.ebreak | irq_ok);

  always_comb begin
    trap_mstatus        = bus.r_mstatus;
    trap_mstatus[7]     = bus.r_mstatus[3];
    trap_mstatus[3]     = 1'b0;
    trap_mstatus[12:11] = 2'b11;
    mret_mstatus        = bus.r_mstatus;
    mret_mstatus[3]     = bus.r_mstatus[7];
    mret_mstatus[7]     = 1'b1;
    mret_mstatus[12:11] = 2'b11;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mstatus_q <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
      target_q  <= '0;
    end else begin
      state_q   <= state_d;
      mstatus_q <= mstatus_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
      target_q  <= target_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    mstatus_d         = mstatus_q;
    mepc_d            = mepc_q;
    mcause_d          = mcause_q;
    target_d          = target_q;
    bus.w_enable      = 1'b0;
    bus.w_ctrl_enable = 1'b0;
    bus.w_mstatus     = '0;
    bus.w_mepc        = '0;
    bus.w_mcause      = '0;
    bus.hold          = 1'b0;
    bus.flush         = 1'b0;
    bus.jump          = 1'b0;
    bus.jump_addr     = '0;
    bus.int_ack       = 1'b0;

    case (state_q)
      IDLE: begin
        // rst_n gate keeps the combinational accept outputs quiet while reset is held
        if (rst_n && req) begin
          bus.flush = 1'b1;
          bus.hold  = 1'b1;
          state_d   = WRITE;
          if (bus.mret) begin
            mstatus_d = mret_mstatus;
            mepc_d    = bus.r_mepc;
            mcause_d  = bus.r_mcause;
            target_d  = bus.r_mepc;
          end else begin
            mstatus_d = trap_mstatus;
            mepc_d    = bus.inst_addr;
            target_d  = {bus.r_mtvec[XLEN-1:2], 2'b00};
            if (bus.ecall)       mcause_d = CAUSE_ECALL;
            else if (bus.ebreak) mcause_d = CAUSE_EBREAK;
            else begin
              mcause_d    = CAUSE_EXTINT;
              bus.int_ack = 1'b1;
            end
          end
        end
      end
      WRITE: begin
        bus.w_enable      = 1'b1;
        bus.w_ctrl_enable = 1'b1;
        bus.w_mstatus     = mstatus_q;
        bus.w_mepc        = mepc_q;
        bus.w_mcause      = mcause_q;
        bus.hold          = 1'b1;
        state_d           = JUMP;
      end
      JUMP: begin
        bus.jump      = 1'b1;
        bus.jump_addr = target_q;
        bus.flush     = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
